// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the fetch stage and the instruction decoder.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;

    // Major opcodes, shared with the decoder
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is presented from registers.
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    // Flush wins; a push into a full FIFO is accepted only alongside a pop
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CW'(DEPTH));

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: fetch PC, credit-limited imem requests, in-order response
// buffering and redirect flush towards decode.
module instruction_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instruction,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_plus4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            started_q, started_d;

    logic            req_fire, rsp_keep, if_pop;
    logic [CW:0]     occupancy;

    logic [XLEN-1:0] tag_head;
    logic            tag_full, tag_empty;
    logic [CW-1:0]   tag_count;

    fetch_entry_t    ibuf_push, ibuf_head;
    logic [EW-1:0]   ibuf_head_raw;
    logic            ibuf_full, ibuf_empty;
    logic [CW-1:0]   ibuf_count;
    logic            unused_c;

    // Credit, redirect and counter bookkeeping; redirect overrides every other event
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        started_d     = 1'b1;

        if_pop    = if_valid && if_ready;
        occupancy = {1'b0, ibuf_count} + {1'b0, outstanding_q} - (CW+1)'(if_pop);
        imem_req_valid = started_q && !redirect_valid && !tag_full
                         && (!ibuf_full || if_pop)
                         && (occupancy < (CW+1)'(FIFO_DEPTH));
        req_fire = imem_req_valid && imem_req_ready;
        rsp_keep = imem_rsp_valid && !redirect_valid && (discard_q == '0) && !tag_empty;

        if (redirect_valid) begin
            fetch_pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
            outstanding_d = outstanding_q - CW'(imem_rsp_valid);
            discard_d     = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
            if (imem_rsp_valid && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            started_q     <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            started_q     <= started_d;
        end
    end

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_keep),
        .flush     (redirect_valid),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    assign ibuf_push = '{instr: imem_rsp_data, pc: tag_head};

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data (ibuf_push),
        .pop       (if_pop),
        .flush     (redirect_valid),
        .head      (ibuf_head_raw),
        .full      (ibuf_full),
        .empty     (ibuf_empty),
        .count     (ibuf_count)
    );

    assign ibuf_head      = ibuf_head_raw;
    assign if_valid       = !ibuf_empty;
    assign if_instruction = if_valid ? ibuf_head.instr : NOP_INSTR;
    assign if_pc          = if_valid ? ibuf_head.pc : RESET_PC;
    assign if_pc_plus4    = if_pc + XLEN'(4);
    assign imem_req_addr  = fetch_pc_q;

    // Address alignment bits are dropped by design; tag occupancy is implied by outstanding
    assign unused_c = ^{redirect_pc[1:0], tag_count};

    a_outstanding_bound: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding_q <= CW'(FIFO_DEPTH));
    a_discard_bound: assert property (@(posedge clk) disable iff (!rst_n)
        discard_q <= outstanding_q);

endmodule
